score_display_sequencer: RTL

SCORE_DISPLAY_SEQUENCER -- requirements
Module: score_display_sequencer

---
 rtl/score_display_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/score_display_sequencer.sv
// Rotating score display: each enabled player gets a blinking "player number" intro (BLINK)
// followed by a frozen snapshot of their two-digit BCD score (DISPLAY).
module score_display_sequencer #(
    parameter int NUM_PLAYERS   = 2,
    parameter int BLINK_MS      = 2000,
    parameter int DISPLAY_MS    = 3000,
    parameter int BLINK_HALF_MS = 250
) (
    input  logic                     clk_1khz,
    input  logic                     rst_i,
    input  logic [8*NUM_PLAYERS-1:0] scores_i,
    input  logic [NUM_PLAYERS-1:0]   enable_mask_i,
    input  logic                     hold_i,
    input  logic                     advance_i,
    output logic [3:0]               tens_o,
    output logic [3:0]               ones_o,
    output logic                     blank_o,
    output logic [2:0]               player_o
);

    localparam int MAX_A   = (BLINK_MS > DISPLAY_MS) ? BLINK_MS : DISPLAY_MS;
    localparam int MAX_LEN = (MAX_A > BLINK_HALF_MS) ? MAX_A : BLINK_HALF_MS;
    localparam int CNT_W   = $clog2(MAX_LEN);

    localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_MS - 1);
    localparam logic [CNT_W-1:0] DISPLAY_LAST = CNT_W'(DISPLAY_MS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(BLINK_HALF_MS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BLINK   = 2'd1;
    localparam logic [1:0] S_DISPLAY = 2'd2;

    function automatic logic [3:0] sat_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    logic [1:0]       r_state, w_state_next;
    logic [CNT_W-1:0] r_phase, w_phase_next;
    logic [CNT_W-1:0] r_half, w_half_next;
    logic [7:0]       r_snap, w_snap_next;
    logic [3:0]       r_tens, w_tens_next;
    logic [3:0]       r_ones, w_ones_next;
    logic             r_blank, w_blank_next;
    logic [2:0]       r_player, w_player_next;

    logic [7:0] w_scores [8];
    logic [7:0] w_mask;
    logic [2:0] w_lowest;
    logic [2:0] w_next_player;
    logic [3:0] w_cand;
    logic       w_found;
    logic       w_go_blink;
    logic [2:0] w_go_player;

    // Pad to eight channels so the player index is always an exact-width select.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_unpack
            if (gi < NUM_PLAYERS) begin : g_used
                assign w_scores[gi] = scores_i[8*gi +: 8];
                assign w_mask[gi]   = enable_mask_i[gi];
            end else begin : g_pad
                assign w_scores[gi] = 8'd0;
                assign w_mask[gi]   = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        w_lowest = 3'd0;
        for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
            if (w_mask[3'(k)]) w_lowest = 3'(k);
        end
    end

    // Ascending search after the current player, wrapping; the current player is tried last.
    always_comb begin
        w_next_player = r_player;
        w_found       = 1'b0;
        w_cand        = 4'd0;
        for (int k = 1; k <= NUM_PLAYERS; k++) begin
            w_cand = {1'b0, r_player} + 4'(k);
            if (w_cand >= 4'(NUM_PLAYERS)) w_cand = w_cand - 4'(NUM_PLAYERS);
            if (!w_found && w_mask[w_cand[2:0]]) begin
                w_next_player = w_cand[2:0];
                w_found       = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_phase_next  = r_phase;
        w_half_next   = r_half;
        w_snap_next   = r_snap;
        w_tens_next   = r_tens;
        w_ones_next   = r_ones;
        w_blank_next  = r_blank;
        w_player_next = r_player;
        w_go_blink    = 1'b0;
        w_go_player   = w_next_player;

        if (w_mask == 8'd0) begin
            w_state_next = S_IDLE;
            w_phase_next = '0;
            w_half_next  = '0;
            w_tens_next  = 4'd0;
            w_ones_next  = 4'd0;
            w_blank_next = 1'b1;
        end else begin
            case (r_state)
                S_BLINK: begin
                    if (!w_mask[r_player]) begin
                        w_go_blink = 1'b1;
                    end else if (r_phase == BLINK_LAST) begin
                        w_state_next = S_DISPLAY;
                        w_phase_next = '0;
                        w_half_next  = '0;
                        w_snap_next  = w_scores[r_player];
                        w_tens_next  = sat_bcd(w_scores[r_player][7:4]);
                        w_ones_next  = sat_bcd(w_scores[r_player][3:0]);
                        w_blank_next = 1'b0;
                    end else begin
                        w_phase_next = r_phase + 1'b1;
                        if (r_half == HALF_LAST) begin
                            w_half_next  = '0;
                            w_blank_next = ~r_blank;
                        end else begin
                            w_half_next = r_half + 1'b1;
                        end
                    end
                end
                S_DISPLAY: begin
                    if (!w_mask[r_player] || advance_i) begin
                        w_go_blink = 1'b1;
                    end else if (!hold_i) begin
                        if (r_phase == DISPLAY_LAST) w_go_blink = 1'b1;
                        else                         w_phase_next = r_phase + 1'b1;
                    end
                    w_tens_next = sat_bcd(r_snap[7:4]);
                    w_ones_next = sat_bcd(r_snap[3:0]);
                end
                default: begin
                    w_go_blink  = 1'b1;
                    w_go_player = w_lowest;
                end
            endcase

            if (w_go_blink) begin
                w_state_next  = S_BLINK;
                w_player_next = w_go_player;
                w_phase_next  = '0;
                w_half_next   = '0;
                w_tens_next   = 4'd0;
                w_ones_next   = {1'b0, w_go_player} + 4'd1;
                w_blank_next  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_1khz or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_half   <= '0;
            r_snap   <= 8'd0;
            r_tens   <= 4'd0;
            r_ones   <= 4'd0;
            r_blank  <= 1'b1;
            r_player <= 3'd0;
        end else begin
            r_state  <= w_state_next;
            r_phase  <= w_phase_next;
            r_half   <= w_half_next;
            r_snap   <= w_snap_next;
            r_tens   <= w_tens_next;
            r_ones   <= w_ones_next;
            r_blank  <= w_blank_next;
            r_player <= w_player_next;
        end
    end

    assign tens_o   = r_tens;
    assign ones_o   = r_ones;
    assign blank_o  = r_blank;
    assign player_o = r_player;

endmodule
